// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: op and state encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

    // func3 encodings of the RV M-extension ops
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        OP_MUL    = F3_MUL,
        OP_MULH   = F3_MULH,
        OP_MULHSU = F3_MULHSU,
        OP_MULHU  = F3_MULHU,
        OP_DIV    = F3_DIV,
        OP_DIVU   = F3_DIVU,
        OP_REM    = F3_REM,
        OP_REMU   = F3_REMU
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIN  = 2'd2
    } md_state_e;

    // Divide-family ops share the restoring-divide datapath.
    function automatic logic op_is_div(md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // Ops whose result is the remainder rather than the quotient.
    function automatic logic op_is_rem(md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // rs1 is interpreted as two's complement. MUL is excluded because the
    // low half of the product is identical either way.
    function automatic logic op_signed_a(md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is interpreted as two's complement.
    function automatic logic op_signed_b(md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide: shift-add multiply, restoring divide, 1 bit/cycle.
// Latency: XLEN+1 edges from accepted start to done; 1 edge for div-by-zero/overflow when EARLY_OUT.
// Backpressure: none; start is ignored (not queued) while busy, so the issuer must stall on busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    // Control state
    md_state_e       state;
    md_op_e          op_q;
    logic [CW-1:0]   cnt;
    logic            neg_res;   // product / quotient must be negated
    logic            neg_rem;   // remainder takes the dividend's (negative) sign
    logic            special;   // result comes from spec_res, not the datapath
    logic [XLEN-1:0] spec_res;

    // Datapath: {acc, lo} is the 2*XLEN product register for multiply;
    // for divide acc is the partial remainder and lo shifts dividend bits
    // out while quotient bits shift in. opnd is multiplicand or divisor.
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;

    // Request decode
    md_op_e          op_in;
    logic            a_neg;
    logic            b_neg;
    logic            is_div_in;
    logic            is_rem_in;
    logic            div_zero;
    logic            div_ovf;
    logic            special_in;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] spec_val;

    // Per-cycle step
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] step_acc;
    logic [XLEN-1:0] step_lo;

    // Completion
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_val;

    // Decode the incoming request: operand signs, magnitudes and the
    // divide corner cases whose answer is fixed by the ISA.
    always_comb begin
        op_in     = md_op_e'(func3);
        is_div_in = op_is_div(op_in);
        is_rem_in = op_is_rem(op_in);
        a_neg     = op_signed_a(op_in) & rs1_data[XLEN-1];
        b_neg     = op_signed_b(op_in) & rs2_data[XLEN-1];
        // Negating MIN_NEG yields MIN_NEG, which is the correct unsigned magnitude.
        abs_a     = a_neg ? -rs1_data : rs1_data;
        abs_b     = b_neg ? -rs2_data : rs2_data;
        div_zero  = (rs2_data == '0);
        div_ovf   = op_signed_b(op_in) && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
        special_in = is_div_in && (div_zero || div_ovf);
        if (div_zero) begin
            spec_val = is_rem_in ? rs1_data : ALL_ONES;
        end else begin
            spec_val = is_rem_in ? '0 : rs1_data;
        end
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_is_div(op_q)) begin
            // div_diff[XLEN] set means the trial subtraction went negative: restore.
            if (!div_diff[XLEN]) begin
                step_acc = div_diff[XLEN-1:0];
                step_lo  = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_acc = div_shift[XLEN-1:0];
                step_lo  = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign-correct the magnitudes and pick the half/part the op returns.
    always_comb begin
        prod_raw = {acc, lo};
        prod_fix = neg_res ? -prod_raw : prod_raw;
        quo_fix  = neg_res ? -lo : lo;
        rem_fix  = neg_rem ? -acc : acc;
        case (op_q)
            OP_MUL:                       fin_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_val = quo_fix;
            default:                      fin_val = rem_fix;
        endcase
        if (special) begin
            fin_val = spec_res;
        end
    end

    // Control FSM plus datapath registers; reset beats flush, flush beats start/completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
            opnd     <= '0;
            acc      <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        op_q     <= op_in;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        special  <= special_in;
                        spec_res <= spec_val;
                        acc      <= '0;
                        cnt      <= CW'(XLEN - 1);
                        busy     <= 1'b1;
                        // Multiplier sits in lo so its LSB steers each add;
                        // the dividend sits in lo so its MSB feeds the remainder.
                        if (is_div_in) begin
                            opnd <= abs_b;
                            lo   <= abs_a;
                        end else begin
                            opnd <= abs_a;
                            lo   <= abs_b;
                        end
                        if ((EARLY_OUT != 0) && special_in) begin
                            state <= MD_FIN;
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= step_acc;
                        lo  <= step_lo;
                        if (cnt == '0) begin
                            state <= MD_FIN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                MD_FIN: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        result <= fin_val;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32 with early-out and XLEN=16 without.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_s   [2];
    logic        start_s [2];
    logic        flush_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [2:0]  f3_s    [2];
    logic [63:0] a_s     [2];
    logic [63:0] b_s     [2];
    logic [31:0] res32;
    logic [15:0] res16;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1)) dut32 (
        .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .func3(f3_s[0]),
        .rs1_data(a_s[0][31:0]), .rs2_data(b_s[0][31:0]), .flush(flush_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .result(res32)
    );

    muldiv_unit #(.XLEN(16), .EARLY_OUT(0)) dut16 (
        .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .func3(f3_s[1]),
        .rs1_data(a_s[1][15:0]), .rs2_data(b_s[1][15:0]), .flush(flush_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .result(res16)
    );

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] last_res [2];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [63:0] get_res(int d);
        return (d == 0) ? {32'd0, res32} : {48'd0, res16};
    endfunction

    function automatic logic [63:0] xmask(int xl);
        return (64'd1 << xl) - 64'd1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain wide-integer arithmetic on the ISA definitions.
    function automatic logic [63:0] ref_md(int xl, logic [2:0] f, logic [63:0] a, logic [63:0] b);
        logic [127:0]        m, au, bu, r;
        logic signed [127:0] as_v, bs_v, p;
        m    = (128'd1 << xl) - 128'd1;
        au   = {64'd0, a} & m;
        bu   = {64'd0, b} & m;
        as_v = au[xl-1] ? $signed(au | ~m) : $signed(au);
        bs_v = bu[xl-1] ? $signed(bu | ~m) : $signed(bu);
        case (f)
            3'b000: r = au * bu;
            3'b001: begin p = as_v * bs_v;        r = p >>> xl; end
            3'b010: begin p = as_v * $signed(bu); r = p >>> xl; end
            3'b011: r = (au * bu) >> xl;
            3'b100: begin
                if (bu == 0) r = m;
                else begin p = as_v / bs_v; r = p; end
            end
            3'b101: r = (bu == 0) ? m : au / bu;
            3'b110: begin
                if (bu == 0) r = au;
                else begin p = as_v % bs_v; r = p; end
            end
            default: r = (bu == 0) ? au : au % bu;
        endcase
        return 64'(r & m);
    endfunction

    // Edges from the start-sampling edge until done is high.
    function automatic int latency(int d, logic [2:0] f, logic [63:0] a, logic [63:0] b);
        int          xl;
        logic [63:0] m;
        logic        spc;
        xl  = (d == 0) ? 32 : 16;
        m   = xmask(xl);
        spc = f[2] && (((b & m) == 0) ||
              (!f[0] && ((a & m) == (64'd1 << (xl - 1))) && ((b & m) == m)));
        return (spc && d == 0) ? 1 : xl + 1;
    endfunction

    function automatic logic [63:0] rnd_opnd(int xl);
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return xmask(xl);
            2:       return 64'd1 << (xl - 1);
            3:       return 64'($urandom_range(0, 9));
            default: return {32'($urandom), 32'($urandom)} & xmask(xl);
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    task automatic score(int d);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        n_cmp++;
        if (!have) begin
            n_err++;
            $display("FAIL unexpected_done dut%0d: actual done=1 required done=0 (cycle %0d)", d, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("result dut%0d", d), get_res(d), e.res);
            check($sformatf("done_cycle dut%0d", d), 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (done_s[0]) score(0);
        if (done_s[1]) score(1);
    end

    task automatic issue(int d, logic [2:0] f, logic [63:0] a, logic [63:0] b,
                         bit push, logic [63:0] er, output int lat);
        exp_t e;
        lat = latency(d, f, a, b);
        @(posedge clk); #1;
        f3_s[d]    = f;
        a_s[d]     = a;
        b_s[d]     = b;
        start_s[d] = 1'b1;
        if (push) begin
            e.res = er;
            e.cyc = cyc + 1 + lat;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            last_res[d] = er;
        end
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic run(int d, logic [2:0] f, logic [63:0] a, logic [63:0] b, logic [63:0] er);
        int lat;
        int n;
        issue(d, f, a, b, 1'b1, er, lat);
        n = 0;
        while (busy_s[d] && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check($sformatf("busy_cycles dut%0d f3=%0d", d, f), 64'(n), 64'(lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual still running required finished (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [2:0]  f;
        logic [63:0] a, b;

        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; start_s[d] = 1'b0; flush_s[d] = 1'b0;
            f3_s[d] = 3'b000; a_s[d] = 64'd0; b_s[d] = 64'd0; last_res[d] = 64'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_busy dut%0d", d), 64'(busy_s[d]), 64'd0);
            check($sformatf("reset_done dut%0d", d), 64'(done_s[d]), 64'd0);
            check($sformatf("reset_result dut%0d", d), get_res(d), 64'd0);
        end
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // Directed XLEN=32 cases
        run(0, 3'b000, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB);
        run(0, 3'b001, 64'h80000000, 64'h80000000, 64'h40000000);
        run(0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE);
        run(0, 3'b010, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF);
        run(0, 3'b100, 64'h5,        64'h0,        64'hFFFFFFFF);
        run(0, 3'b111, 64'h5,        64'h0,        64'h5);
        run(0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000);
        run(0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h0);
        run(0, 3'b100, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD);
        run(0, 3'b110, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF);

        // Flush mid-CALC, with a start pulse while busy that must be dropped
        issue(0, 3'b101, 64'd1000, 64'd7, 1'b0, 64'd0, lat);
        @(posedge clk); #1;
        f3_s[0] = 3'b000; a_s[0] = 64'd3; b_s[0] = 64'd3; start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy_before_flush", 64'(busy_s[0]), 64'd1);
        flush_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0;
        check("flush_busy", 64'(busy_s[0]), 64'd0);
        check("flush_result_kept", get_res(0), last_res[0]);
        repeat (40) @(posedge clk);
        #1;
        check("busy_start_not_queued", 64'(busy_s[0]), 64'd0);

        // Flush while in FIN (early-out path) beats completion
        issue(0, 3'b100, 64'd5, 64'd0, 1'b0, 64'd0, lat);
        flush_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0;
        check("flush_fin_busy", 64'(busy_s[0]), 64'd0);
        check("flush_fin_result_kept", get_res(0), last_res[0]);

        // Flush and start together in IDLE: request dropped
        f3_s[0] = 3'b000; a_s[0] = 64'd2; b_s[0] = 64'd3;
        start_s[0] = 1'b1; flush_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        check("flush_start_idle_busy", 64'(busy_s[0]), 64'd0);
        repeat (40) @(posedge clk);

        // Directed XLEN=16 cases (no early-out: corner cases take full latency)
        run(1, 3'b101, 64'hFFFF, 64'h3,    64'h5555);
        run(1, 3'b100, 64'h8000, 64'hFFFF, 64'h8000);
        run(1, 3'b110, 64'h8000, 64'hFFFF, 64'h0);
        run(1, 3'b111, 64'h7,    64'h0,    64'h7);
        run(1, 3'b100, 64'h7,    64'h0,    64'hFFFF);
        run(1, 3'b001, 64'h8000, 64'h8000, 64'h4000);

        // Reset mid-CALC abandons the op and clears the outputs
        issue(1, 3'b101, 64'hFFFF, 64'h3, 1'b0, 64'd0, lat);
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid_calc16", 64'(busy_s[1]), 64'd1);
        rst_s[1] = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", 64'(busy_s[1]), 64'd0);
        check("midreset_done", 64'(done_s[1]), 64'd0);
        check("midreset_result", get_res(1), 64'd0);
        // Reset also overrides a simultaneous start
        f3_s[1] = 3'b000; a_s[1] = 64'd4; b_s[1] = 64'd5; start_s[1] = 1'b1;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        rst_s[1] = 1'b0;
        check("reset_over_start_busy", 64'(busy_s[1]), 64'd0);
        last_res[1] = 64'd0;
        repeat (20) @(posedge clk);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rnd_opnd(32);
            b = rnd_opnd(32);
            run(0, f, a, b, ref_md(32, f, a, b));
        end
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rnd_opnd(16);
            b = rnd_opnd(16);
            run(1, f, a, b, ref_md(16, f, a, b));
        end

        repeat (5) @(posedge clk);
        check("pending_dut32", 64'(q0.size()), 64'd0);
        check("pending_dut16", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
